// File: rtl/ladybird_icache_pkg.sv
// rtl/ladybird_icache_pkg.sv - shared configuration for the ladybird instruction cache
package ladybird_icache_pkg;

  localparam int XLEN         = 32;
  localparam int ICACHE_LINES = 16;

  function automatic int tag_width(input int lines);
    return XLEN - $clog2(lines) - 2;
  endfunction

endpackage

// File: rtl/ladybird_icache_if.sv
// rtl/ladybird_icache_if.sv - core-side and MMU-side fetch handshakes of the icache
interface ladybird_icache_if;
  import ladybird_icache_pkg::*;

  logic [XLEN-1:0] c_pc;
  logic            c_pc_valid;
  logic            c_pc_ready;
  logic [XLEN-1:0] c_inst;
  logic            c_inst_valid;
  logic [XLEN-1:0] m_pc;
  logic            m_pc_valid;
  logic            m_pc_ready;
  logic [XLEN-1:0] m_inst;
  logic            m_inst_valid;

  modport slave (
    input  c_pc, c_pc_valid, m_pc_ready, m_inst, m_inst_valid,
    output c_pc_ready, c_inst, c_inst_valid, m_pc, m_pc_valid
  );

  modport master (
    output c_pc, c_pc_valid, m_pc_ready, m_inst, m_inst_valid,
    input  c_pc_ready, c_inst, c_inst_valid, m_pc, m_pc_valid
  );

endinterface

// File: rtl/ladybird_icache_ram.sv
// rtl/ladybird_icache_ram.sv - tag+data line storage, synchronous write, combinational read
module ladybird_icache_ram #(
  parameter int LINES  = 16,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [TAG_W-1:0]  rtag,
  output logic [DATA_W-1:0] rdata
);

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[waddr]  <= wtag;
      data_mem[waddr] <= wdata;
    end
  end

  assign rtag  = tag_mem[raddr];
  assign rdata = data_mem[raddr];

endmodule

// File: rtl/ladybird_icache.sv
// rtl/ladybird_icache.sv - direct-mapped one-word-per-line instruction cache between core fetch and MMU
module ladybird_icache
  import ladybird_icache_pkg::*;
#(
  parameter int LINES = ICACHE_LINES
) (
  input  logic              clk,
  input  logic              rst,
  ladybird_icache_if.slave  bus,
  input  logic              flush,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tag_width(LINES);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} icache_state_t;

  icache_state_t   state_q, state_d;
  logic [XLEN-1:0] req_pc_q;
  logic [LINES-1:0] valid_q;
  logic            flush_pend_q;
  logic [XLEN-1:0] c_inst_q;
  logic            c_inst_valid_q;
  logic [XLEN-1:0] m_pc_q;
  logic            m_pc_valid_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] rd_tag;
  logic [XLEN-1:0]  rd_data;
  logic             accept, hit, refill_done, refill_alloc;

  assign req_idx = req_pc_q[IDX_W+1:2];
  assign req_tag = req_pc_q[XLEN-1:IDX_W+2];

  assign bus.c_pc_ready   = (state_q == IDLE) && !flush;
  assign bus.c_inst       = c_inst_q;
  assign bus.c_inst_valid = c_inst_valid_q;
  assign bus.m_pc         = m_pc_q;
  assign bus.m_pc_valid   = m_pc_valid_q;

  assign accept       = bus.c_pc_valid && bus.c_pc_ready;
  // A flush landing on the lookup cycle must not return a line it is invalidating.
  assign hit          = valid_q[req_idx] && (rd_tag == req_tag) && !flush;
  assign refill_done  = (state_q == MISS_WAIT) && bus.m_inst_valid;
  assign refill_alloc = refill_done && !flush_pend_q && !flush;

  ladybird_icache_ram #(
    .LINES  (LINES),
    .TAG_W  (TAG_W),
    .DATA_W (XLEN),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (refill_alloc),
    .waddr (req_idx),
    .wtag  (req_tag),
    .wdata (bus.m_inst),
    .raddr (req_idx),
    .rtag  (rd_tag),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = LOOKUP;
      LOOKUP:    state_d = hit ? IDLE : MISS_REQ;
      MISS_REQ:  if (bus.m_pc_ready) state_d = MISS_WAIT;
      MISS_WAIT: if (bus.m_inst_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q       <= '0;
      valid_q        <= '0;
      flush_pend_q   <= 1'b0;
      c_inst_q       <= '0;
      c_inst_valid_q <= 1'b0;
      m_pc_q         <= '0;
      m_pc_valid_q   <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      c_inst_valid_q <= 1'b0;
      if (accept) req_pc_q <= bus.c_pc;
      if (state_q == LOOKUP) begin
        if (hit) begin
          c_inst_q       <= rd_data;
          c_inst_valid_q <= 1'b1;
          hit_count      <= hit_count + 32'd1;
        end else begin
          m_pc_q       <= req_pc_q;
          m_pc_valid_q <= 1'b1;
          miss_count   <= miss_count + 32'd1;
        end
      end
      if (state_q == MISS_REQ && bus.m_pc_ready) m_pc_valid_q <= 1'b0;
      if (flush && (state_q == MISS_REQ || state_q == MISS_WAIT)) flush_pend_q <= 1'b1;
      if (refill_done) begin
        c_inst_q       <= bus.m_inst;
        c_inst_valid_q <= 1'b1;
        flush_pend_q   <= 1'b0;
      end
      if (flush)             valid_q          <= '0;
      else if (refill_alloc) valid_q[req_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ladybird_icache.sv
// tb/tb_ladybird_icache.sv - randomized self-checking bench for ladybird_icache
module tb_ladybird_icache;
  import ladybird_icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] hit_count, miss_count;

  ladybird_icache_if bus();

  ladybird_icache #(.LINES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, pending = 0, hs_cnt = 0, vld_cnt = 0;
  bit          miss_active = 0;
  logic [31:0] miss_addr = '0;
  logic [31:0] last_inst = '0;
  int          m_hits = 0, m_misses = 0;
  bit          mv [16];
  logic [29:0] mline [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a[31:2] == 30'h40) return 32'h13;
    return ({2'b00, a[31:2]} * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic void model_invalidate();
    for (int i = 0; i < 16; i++) mv[i] = 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: a little after the falling edge, well clear of DUT updates and stimulus.
  always @(negedge clk) begin : cmp
    exp_t e;
    #2;
    if (!rst) begin
      if (bus.m_pc_valid && bus.m_pc_ready) hs_cnt++;
      if (bus.m_pc_valid) begin
        chk("m_pc_valid_expected", {31'd0, miss_active}, 32'd1);
        chk("m_pc", bus.m_pc, miss_addr);
      end
      if (bus.c_inst_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_c_inst_valid: got c_inst_valid=1 with 0x%08h, required no pulse", bus.c_inst);
        end else begin
          e = exp_q.pop_front();
          chk("c_inst", bus.c_inst, e.data);
          if (e.hit) chk("hit_latency", cyc - e.acc, 32'd2);
          chk("hit_count", hit_count, m_hits);
          chk("miss_count", miss_count, m_misses);
          last_inst = e.data;
          pending--;
        end
      end else begin
        chk("c_inst_hold", bus.c_inst, last_inst);
      end
    end
  end

  task automatic wait_m_pc_valid();
    int t = 0;
    while (!bus.m_pc_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("m_pc_valid_timeout", {31'd0, t < 20}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a, input int dly, input int lat, input bit fl_wait);
    exp_t e;
    bit   hit;
    int   idx = int'(a[5:2]);
    int   t;
    hit = mv[idx] && (mline[idx] == a[31:2]);
    @(negedge clk);
    chk("c_pc_ready_idle", {31'd0, bus.c_pc_ready}, 32'd1);
    e.data = mem(a);
    e.hit  = hit;
    e.acc  = cyc;
    exp_q.push_back(e);
    pending++;
    if (hit) m_hits++;
    else begin
      m_misses++;
      miss_active = 1;
      miss_addr   = a;
    end
    bus.c_pc       = a;
    bus.c_pc_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.c_pc_valid = 1'b0;
    bus.c_pc       = $urandom;
    if (!hit) begin
      wait_m_pc_valid();
      for (int d = 0; d < dly; d++) begin
        chk("bp_m_pc_valid", {31'd0, bus.m_pc_valid}, 32'd1);
        chk("bp_m_pc", bus.m_pc, a);
        chk("bp_c_pc_ready", {31'd0, bus.c_pc_ready}, 32'd0);
        @(negedge clk);
      end
      bus.m_pc_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.m_pc_ready = 1'b0;
      miss_active    = 0;
      if (fl_wait) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_invalidate();
      end
      repeat (lat) @(negedge clk);
      @(negedge clk);
      bus.m_inst       = mem(a);
      bus.m_inst_valid = 1'b1;
      @(negedge clk);
      bus.m_inst_valid = 1'b0;
      bus.m_inst       = $urandom;
      if (!fl_wait) begin
        mv[idx]    = 1;
        mline[idx] = a[31:2];
      end
    end
    t = 0;
    while (pending > 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("deliver_timeout", pending, 32'd0);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("c_pc_ready_flush", {31'd0, bus.c_pc_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    model_invalidate();
  endtask

  task automatic reset_mid_miss(input logic [31:0] a);
    int v0;
    @(negedge clk);
    miss_active    = 1;
    miss_addr      = a;
    bus.c_pc       = a;
    bus.c_pc_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.c_pc_valid = 1'b0;
    wait_m_pc_valid();
    bus.m_pc_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_pc_ready = 1'b0;
    miss_active    = 0;
    @(negedge clk);
    rst = 1'b1;
    m_hits = 0;
    m_misses = 0;
    last_inst = '0;
    model_invalidate();
    @(negedge clk);
    rst = 1'b0;
    v0 = vld_cnt;
    @(negedge clk);
    bus.m_inst       = mem(a);
    bus.m_inst_valid = 1'b1;
    @(negedge clk);
    bus.m_inst_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_valid_after_reset", vld_cnt - v0, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    fetch(a, 0, 1, 0);
    chk("miss_after_reset", miss_count, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    bus.c_pc = '0;
    bus.c_pc_valid = 1'b0;
    bus.m_pc_ready = 1'b0;
    bus.m_inst = '0;
    bus.m_inst_valid = 1'b0;
    model_invalidate();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_c_inst", bus.c_inst, 32'd0);
    chk("reset_c_inst_valid", {31'd0, bus.c_inst_valid}, 32'd0);
    chk("reset_m_pc", bus.m_pc, 32'd0);
    chk("reset_m_pc_valid", {31'd0, bus.m_pc_valid}, 32'd0);
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);
    chk("reset_c_pc_ready", {31'd0, bus.c_pc_ready}, 32'd1);

    fetch(32'h0000_0100, 0, 3, 0);
    chk("cold_inst", bus.c_inst, 32'h13);
    chk("cold_miss_count", miss_count, 32'd1);
    chk("cold_hit_count", hit_count, 32'd0);
    chk("cold_handshakes", hs_cnt, 32'd1);

    fetch(32'h0000_0100, 0, 0, 0);
    chk("hit_inst", bus.c_inst, 32'h13);
    chk("hit_hit_count", hit_count, 32'd1);
    chk("hit_handshakes", hs_cnt, 32'd1);

    fetch(32'h0000_0140, 1, 2, 0);
    fetch(32'h0000_0100, 0, 1, 0);
    chk("conflict_miss_count", miss_count, 32'd3);

    do_flush();
    fetch(32'h0000_0100, 0, 0, 0);
    chk("flush_idle_miss_count", miss_count, 32'd4);

    fetch(32'h0000_0140, 0, 2, 1);
    fetch(32'h0000_0140, 0, 0, 0);
    chk("flush_wait_miss_count", miss_count, 32'd6);

    fetch(32'h0000_0180, 5, 1, 0);
    chk("bp_miss_count", miss_count, 32'd7);

    reset_mid_miss(32'h0000_0200);

    for (int n = 0; n < 300; n++) begin
      a = {(($urandom & 1) != 0) ? 16'h8000 : 16'h0000, 6'h0,
           4'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) do_flush();
      else fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end
    repeat (3) @(negedge clk);
    chk("final_hit_count", hit_count, m_hits);
    chk("final_miss_count", miss_count, m_misses);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
